// File: rtl/fire_control.sv
// fire_control: trigger sequencer sitting directly in front of the weapons stage.
// Turns the raw pilot trigger into clean one-cycle fire pulses, in single-shot or
// burst mode, with a programmable cooldown between shots. It gates every shot on ship
// mode, reload state and the ammo level fed back from the weapons stage.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-low reset
//   mode           ship mode (4'b0010 = attack)
//   trigger        raw trigger level, synchronous to clk
//   burst_en       1 = burst of burst_len shots (0 treated as 1), 0 = single shot
//   cooldown       idle cycles between shots, sampled at every shot
//   rate_sel       ammo per shot = 1 << rate_sel
//   ammo_level     ammo count fed back from the weapons stage
//   loading_ammo   reload in progress
//   fire           one-cycle shot pulse
//   fire_rate      ammo decrement latched at sequence start
//   busy           sequence in progress
//   err, err_code  one-cycle error pulse; code 01 mode, 10 ammo, 11 abort (code holds)
//   shots_fired    saturating count of issued shots
module fire_control #(
    parameter int unsigned W     = 9,
    parameter int unsigned CD_W  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       mode,
    input  logic             trigger,
    input  logic             burst_en,
    input  logic [3:0]       burst_len,
    input  logic [CD_W-1:0]  cooldown,
    input  logic [1:0]       rate_sel,
    input  logic [W-1:0]     ammo_level,
    input  logic             loading_ammo,
    output logic             fire,
    output logic [W-1:0]     fire_rate,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] shots_fired
);

    localparam logic [3:0] ModeAttack = 4'b0010;

    typedef enum logic [1:0] {
        StIdle,
        StFire,
        StCool
    } state_e;

    state_e          state;
    logic            trig_q;
    logic [3:0]      shots_left;
    logic [CD_W-1:0] cd_cnt;

    logic [W-1:0] rate_val;
    logic         trig_rise;
    logic         attack;
    logic         abort;
    logic         start_ok;
    logic         cont_ok;

    assign rate_val  = W'(1) << rate_sel;
    assign trig_rise = trigger & ~trig_q;
    assign attack    = (mode == ModeAttack);
    assign abort     = ~attack | loading_ammo;
    assign start_ok  = attack & ~loading_ammo & (ammo_level >= rate_val);
    // Mid-sequence re-checks use the latched rate so rate_sel changes cannot alter a burst.
    assign cont_ok   = attack & ~loading_ammo & (ammo_level >= fire_rate);

    // Moore decode of the state register.
    assign fire = (state == StFire);
    assign busy = (state != StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            trig_q      <= 1'b1;  // a trigger held through reset must not fire
            fire_rate   <= '0;
            shots_left  <= '0;
            cd_cnt      <= '0;
            shots_fired <= '0;
            err         <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            trig_q <= trigger;
            err    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (trig_rise) begin
                        if (start_ok) begin
                            state      <= StFire;
                            fire_rate  <= rate_val;
                            shots_left <= (burst_en && burst_len != 4'd0) ? burst_len : 4'd1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= attack ? 2'b10 : 2'b01;
                        end
                    end
                end
                StFire: begin
                    shots_left <= shots_left - 4'd1;
                    if (shots_fired != '1) begin
                        shots_fired <= shots_fired + CNT_W'(1);
                    end
                    cd_cnt <= (cooldown == '0) ? CD_W'(1) : cooldown;
                    // The shot in this cycle still completes; only later shots are cancelled.
                    if (abort) begin
                        state    <= StIdle;
                        err      <= 1'b1;
                        err_code <= 2'b11;
                    end else begin
                        state <= StCool;
                    end
                end
                StCool: begin
                    cd_cnt <= cd_cnt - CD_W'(1);
                    if (abort) begin
                        state    <= StIdle;
                        err      <= 1'b1;
                        err_code <= 2'b11;
                    end else if (cd_cnt == CD_W'(1)) begin
                        if (shots_left == 4'd0) begin
                            state <= StIdle;
                        end else if (cont_ok) begin
                            state <= StFire;
                        end else begin
                            // Mode and reload are already covered by abort, so only ammo is short.
                            state    <= StIdle;
                            err      <= 1'b1;
                            err_code <= 2'b10;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fire_control.sv
// tb_fire_control: scoreboard bench for fire_control. Each transaction is planned by a
// shot-schedule model (shot times, ammo after each shot, abort window). The expected
// fire/err events are queued, and a negedge monitor pops and compares them whenever the
// DUT pulses fire or err.
module tb_fire_control;

    localparam int unsigned W     = 9;
    localparam int unsigned CD_W  = 8;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       mode = 4'b0010;
    logic             trigger = 1'b0;
    logic             burst_en = 1'b0;
    logic [3:0]       burst_len = 4'd1;
    logic [CD_W-1:0]  cooldown = '0;
    logic [1:0]       rate_sel = 2'd0;
    logic [W-1:0]     ammo_level = '0;
    logic             loading_ammo = 1'b0;
    logic             fire;
    logic [W-1:0]     fire_rate;
    logic             busy;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] shots_fired;

    fire_control #(.W(W), .CD_W(CD_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .trigger      (trigger),
        .burst_en     (burst_en),
        .burst_len    (burst_len),
        .cooldown     (cooldown),
        .rate_sel     (rate_sel),
        .ammo_level   (ammo_level),
        .loading_ammo (loading_ammo),
        .fire         (fire),
        .fire_rate    (fire_rate),
        .busy         (busy),
        .err          (err),
        .err_code     (err_code),
        .shots_fired  (shots_fired)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        int unsigned at;
        logic [1:0]  code;
        int unsigned rate;
        int unsigned cnt;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         mon_e;
    int          errors = 0;
    int          checks = 0;
    int unsigned model_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input bit is_err, input int unsigned at, input logic [1:0] code,
                           input int unsigned rate);
        ev_t e;
        e.is_err = is_err;
        e.at     = at;
        e.code   = code;
        e.rate   = rate;
        e.cnt    = model_cnt;
        if (!is_err && model_cnt < 65535) model_cnt++;
        exp_q.push_back(e);
    endtask

    // Monitor: every fire or err pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst && (fire || err)) begin
            check("fire_err_exclusive", 32'(fire & err), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: fire=%0b err=%0b code=%0d at cycle %0d, none required",
                         fire, err, err_code, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_cycle", 32'(cyc), 32'(mon_e.at));
                check("event_is_err", 32'(err), 32'(mon_e.is_err));
                if (mon_e.is_err) begin
                    check("err_code", 32'(err_code), 32'(mon_e.code));
                end else begin
                    check("fire_rate", 32'(fire_rate), 32'(mon_e.rate));
                    check("shots_fired", 32'(shots_fired), 32'(mon_e.cnt));
                    check("busy_on_fire", 32'(busy), 32'd1);
                end
            end
        end
    end

    // One trigger sequence. Relative cycle 0 carries the rising trigger; abort_at (0 = none)
    // is the relative cycle from which loading_ammo (or a non-attack mode) is held.
    task automatic run_txn(input logic [3:0] md, input logic load0, input logic [1:0] rs,
                           input logic be, input logic [3:0] bl, input logic [CD_W-1:0] cdv,
                           input int unsigned ammo0, input int unsigned abort_at,
                           input bit abort_mode, input bit repulse);
        int unsigned rate = 32'd1 << rs;
        int unsigned n    = be ? ((bl == 4'd0) ? 1 : 32'(bl)) : 1;
        int unsigned cd   = (cdv == '0) ? 1 : 32'(cdv);
        int unsigned shots[$];
        int unsigned last_busy = 0;
        int unsigned am = ammo0;
        int unsigned c0;
        int unsigned t;
        int unsigned left;
        int unsigned am_r;
        logic [3:0]  bad_mode;

        bad_mode = 4'($urandom_range(0, 15));
        if (bad_mode == 4'b0010) bad_mode = 4'b0110;

        @(posedge clk);
        #1;
        c0 = cyc;

        if (md != 4'b0010) begin
            push_ev(1'b1, c0 + 1, 2'b01, 0);
        end else if (load0 || ammo0 < rate) begin
            push_ev(1'b1, c0 + 1, 2'b10, 0);
        end else begin
            t    = 1;
            left = n;
            forever begin
                shots.push_back(t);
                push_ev(1'b0, c0 + t, 2'b00, rate);
                am   = am - rate;
                left = left - 1;
                if (abort_at == t) begin
                    push_ev(1'b1, c0 + t + 1, 2'b11, 0);
                    last_busy = t;
                    break;
                end
                if (abort_at > t && abort_at <= t + cd) begin
                    push_ev(1'b1, c0 + abort_at + 1, 2'b11, 0);
                    last_busy = abort_at;
                    break;
                end
                if (left == 0) begin
                    last_busy = t + cd;
                    break;
                end
                if (am < rate) begin
                    push_ev(1'b1, c0 + t + cd + 1, 2'b10, 0);
                    last_busy = t + cd;
                    break;
                end
                t = t + cd + 1;
            end
        end

        for (int r = 0; r <= int'(last_busy) + 3; r++) begin
            if (r > 0) begin
                @(posedge clk);
                #1;
            end
            if (r == 0) begin
                mode         = md;
                loading_ammo = load0;
                rate_sel     = rs;
                burst_en     = be;
                burst_len    = bl;
                cooldown     = cdv;
            end
            if (r == 1) begin
                // Latched burst settings must not be affected by later input changes.
                burst_len = 4'($urandom_range(0, 15));
                burst_en  = 1'($urandom_range(0, 1));
            end
            trigger = (r == 0) || (repulse && r == 2 && last_busy >= 2);
            am_r = ammo0;
            foreach (shots[k]) if (shots[k] < 32'(r)) am_r = am_r - rate;
            ammo_level = W'(am_r);
            if (abort_at != 0 && 32'(r) >= abort_at) begin
                if (abort_mode) mode = bad_mode;
                else loading_ammo = 1'b1;
            end
            if (last_busy >= 1 && 32'(r) == last_busy) check("busy_last_cycle", 32'(busy), 32'd1);
            if (32'(r) == last_busy + 1) check("busy_dropped", 32'(busy), 32'd0);
        end
        mode         = 4'b0010;
        loading_ammo = 1'b0;
        trigger      = 1'b0;
    endtask

    logic [3:0]      r_md;
    logic            r_load;
    logic [1:0]      r_rs;
    logic            r_be;
    logic [3:0]      r_bl;
    logic [CD_W-1:0] r_cd;
    int unsigned     c_rst;

    initial begin
        // Reset with the trigger already held: no pulse may follow release.
        trigger    = 1'b1;
        ammo_level = W'(100);
        repeat (3) @(posedge clk);
        #1;
        check("rst_fire", 32'(fire), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_fire_rate", 32'(fire_rate), 32'd0);
        check("rst_shots_fired", 32'(shots_fired), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("held_trig_shots", 32'(shots_fired), 32'd0);
        check("held_trig_busy", 32'(busy), 32'd0);
        check("held_trig_code", 32'(err_code), 32'd0);
        trigger = 1'b0;
        repeat (2) @(posedge clk);

        // Directed: single shot, burst, ammo short mid-burst, wrong mode, no ammo, abort.
        run_txn(4'b0010, 1'b0, 2'd0, 1'b0, 4'd1, 8'd3, 100, 0, 1'b0, 1'b0);
        run_txn(4'b0010, 1'b0, 2'd2, 1'b1, 4'd3, 8'd4, 50, 0, 1'b0, 1'b1);
        run_txn(4'b0010, 1'b0, 2'd3, 1'b1, 4'd5, 8'd2, 20, 0, 1'b0, 1'b0);
        run_txn(4'b0001, 1'b0, 2'd0, 1'b0, 4'd1, 8'd1, 100, 0, 1'b0, 1'b0);
        run_txn(4'b0010, 1'b0, 2'd0, 1'b0, 4'd1, 8'd1, 0, 0, 1'b0, 1'b0);
        run_txn(4'b0010, 1'b0, 2'd0, 1'b1, 4'd4, 8'd5, 100, 3, 1'b0, 1'b0);
        run_txn(4'b0010, 1'b0, 2'd1, 1'b1, 4'd0, 8'd0, 9, 0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r_md = 4'b0010;
            if ($urandom_range(0, 9) == 0) begin
                r_md = 4'($urandom_range(0, 15));
                if (r_md == 4'b0010) r_md = 4'b1010;
            end
            r_load = ($urandom_range(0, 9) == 0);
            r_rs   = 2'($urandom_range(0, 3));
            r_be   = 1'($urandom_range(0, 1));
            r_bl   = 4'($urandom_range(0, 15));
            r_cd   = CD_W'($urandom_range(0, 6));
            run_txn(r_md, r_load, r_rs, r_be, r_bl, r_cd, $urandom_range(0, 120),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a burst: outputs clear without a clock edge.
        @(posedge clk);
        #1;
        c_rst        = cyc;
        mode         = 4'b0010;
        loading_ammo = 1'b0;
        rate_sel     = 2'd0;
        burst_en     = 1'b1;
        burst_len    = 4'd4;
        cooldown     = 8'd10;
        ammo_level   = W'(100);
        trigger      = 1'b1;
        push_ev(1'b0, c_rst + 1, 2'b00, 1);
        @(posedge clk);
        #1;
        trigger = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_fire", 32'(fire), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_err", 32'(err), 32'd0);
        check("async_err_code", 32'(err_code), 32'd0);
        check("async_fire_rate", 32'(fire_rate), 32'd0);
        check("async_shots_fired", 32'(shots_fired), 32'd0);
        model_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        run_txn(4'b0010, 1'b0, 2'd1, 1'b0, 4'd1, 8'd2, 30, 0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
